// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side hazard inputs and the stage-control enables returned by the hazard controller.
// master = datapath that supplies hazard info; slave = hazard controller.
interface pipeline_hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic [4:0] ex_rt;
   logic       ex_mem_read;
   logic       ex_branch_taken;
   logic       imem_ready;
   logic       dmem_busy;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       ex_mem_hold;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes, memory freezes.
// Control enables are same-cycle combinational; state, flush counter and stall count are registered.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave bus,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      stall_cycles
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HAZARD  = 2'd1,
      MEMWAIT = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   state_t           eff_state;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q;
   logic             load_use;

   assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                     ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

   // Once a freeze lifts, the retained state is evaluated in the very same cycle.
   assign eff_state = (state_q == MEMWAIT) ? ret_q : state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         ret_q   <= RUN;
         cnt_q   <= 3'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         if (!bus.pc_write && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      if (bus.dmem_busy) begin
         state_d = MEMWAIT;
         if (state_q != MEMWAIT)
            ret_d = state_q;
      end else begin
         case (eff_state)
            FLUSH: begin
               if (cnt_q != 3'd0)
                  cnt_d = cnt_q - 3'd1;
               state_d = (cnt_q <= 3'd1) ? RUN : FLUSH;
            end
            default: begin
               if (bus.ex_branch_taken) begin
                  cnt_d   = FLUSH_LOAD;
                  state_d = FLUSH;
               end else if (load_use) begin
                  state_d = HAZARD;
               end else if (!bus.imem_ready) begin
                  state_d = eff_state;
               end else begin
                  state_d = RUN;
               end
            end
         endcase
      end
   end

   always_comb begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      bus.ex_mem_hold  = 1'b0;
      if (reset) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (bus.dmem_busy) begin
         bus.ex_mem_hold = 1'b1;
      end else if ((eff_state == FLUSH) || bus.ex_branch_taken) begin
         bus.pc_write     = 1'b1;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (load_use || !bus.imem_ready) begin
         bus.id_ex_bubble = 1'b1;
      end else begin
         bus.pc_write    = 1'b1;
         bus.if_id_write = 1'b1;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, legal 1..7: extra bubble cycles after a taken branch.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_rs  in  5  source register A of the instruction in IF_ID.
REQ-006 id_rt  in  5  source register B of the instruction in IF_ID.
REQ-007 id_uses_rt  in  1  1 = the IF_ID instruction reads id_rt.
REQ-008 ex_rt  in  5  destination register of the instruction in ID_EX.
REQ-009 ex_mem_read  in  1  1 = the ID_EX instruction is a load.
REQ-010 ex_branch_taken  in  1  1 = the branch in EX resolved taken this cycle.
REQ-011 imem_ready  in  1  1 = instruction memory returns a valid word this cycle.
REQ-012 dmem_busy  in  1  1 = data memory requests a full pipeline freeze.
REQ-013 pc_write  out  1  PC register load enable.
REQ-014 if_id_write  out  1  IF_ID load enable.
REQ-015 if_id_flush  out  1  clear IF_ID to NOP.
REQ-016 id_ex_bubble  out  1  load NOP into ID_EX instead of decode output.
REQ-017 ex_mem_hold  out  1  hold EX/MEM and later stages.
REQ-018 state  out  2  current FSM state: RUN=0, HAZARD=1, MEMWAIT=2, FLUSH=3.
REQ-019 stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-020 Control outputs are combinational from the current state and inputs (same-cycle); state, flush counter and stall_cycles are registered.
REQ-021 Load-use hazard = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-022 Event priority, highest first: dmem_busy, ex_branch_taken, load-use hazard, !imem_ready, none.
REQ-023 Normal flow (no event, state RUN or HAZARD): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0; next state RUN.
REQ-024 dmem_busy=1 in any state: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=1; next state MEMWAIT; flush counter and the pre-freeze state are retained.
REQ-025 MEMWAIT with dmem_busy=0: return to the retained pre-freeze state and evaluate it in that same cycle.
REQ-026 ex_branch_taken=1 (not busy): pc_write=1, if_id_write=0, if_id_flush=1, id_ex_bubble=1; flush counter loads FLUSH_CYCLES; next state FLUSH.
REQ-027 FLUSH: pc_write=1, if_id_flush=1, id_ex_bubble=1, counter decrements each cycle; FLUSH -> RUN when the counter reaches 0; FLUSH ignores load-use hazards and ex_branch_taken.
REQ-028 Load-use in RUN or HAZARD (not busy, no branch): pc_write=0, if_id_write=0, id_ex_bubble=1; next state HAZARD.
REQ-029 HAZARD with no re-detected hazard: normal flow, next state RUN.
REQ-030 !imem_ready (no higher event, not FLUSH): pc_write=0, if_id_write=0, id_ex_bubble=1; state unchanged.
REQ-031 stall_cycles increments on every clock with pc_write=0 and saturates at all-ones with no wrap.
REQ-032 Register 0 never causes a hazard.

Reset
REQ-033 On reset=1 at a rising edge: state=RUN, flush counter=0, stall_cycles=0, retained state=RUN.
REQ-034 While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
REQ-035 Reset mid-FLUSH or mid-MEMWAIT aborts the sequence; the first post-reset cycle is RUN normal flow.

Verification
REQ-036 Reset 15 ns, clock period 20 ns, idle inputs, imem_ready=1 -> state=0, pc_write=1, stall_cycles=0 after reset release.
REQ-037 ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> 1 cycle pc_write=0 with id_ex_bubble=1, state=1, then RUN; stall_cycles=1.
REQ-038 ex_branch_taken=1 with FLUSH_CYCLES=2 -> if_id_flush=1 for 3 consecutive cycles, state=3 for 2 cycles, then state=0; stall_cycles unchanged.
REQ-039 dmem_busy=1 for 4 cycles during FLUSH (counter=1) -> ex_mem_hold=1 for 4 cycles, state=2, then 1 FLUSH cycle, then RUN; stall_cycles +4.
REQ-040 Simultaneous branch + load-use (ex_rt=id_rt=3, id_uses_rt=1) -> branch wins, state=3, no HAZARD entry; ex_rt=0 with id_rs=0 -> no stall.
REQ-041 Preload stall_cycles to near saturation (CNT_W=4, 16 stalled cycles) -> stall_cycles=15 and holds at 15.
